// File: rtl/riscv_execute_datapath.sv
// riscv_execute_datapath: operand muxes, immediate extender, NZCV ALU and ALUOut register.
// Define ALU_SHIFT_EN to build the SLL/SRL shifter; otherwise ALUControl 110/111 yield zero.
module riscv_execute_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] OldPC,
  input  logic [31:0] A,
  input  logic [31:0] WriteData,
  input  logic [31:0] Result,
  input  logic [24:0] Inst,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic        AddrSrc,
  output logic [31:0] Addr,
  output logic [31:0] ImmExt,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [31:0] ALUResult,
  output logic [31:0] ALUOut,
  output logic        Zero,
  output logic        Negative,
  output logic        Carry,
  output logic        Overflow
);
  logic [31:0] instr;
  logic        s;
  logic        sub;
  logic        arith;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] alu_out_d;
  logic [31:0] alu_out_q;
  assign instr = {Inst, 7'b0};
  assign s     = instr[31];
  always_comb
    ImmExt = ImmSrc == 2'b00 ? {{20{s}}, instr[31:20]} :
             ImmSrc == 2'b01 ? {{20{s}}, instr[31:25], instr[11:7]} :
             ImmSrc == 2'b10 ? {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                               {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign Addr = AddrSrc ? Result : PC;
  always_comb
    SrcA = ALUSrcA == 2'b00 ? PC : ALUSrcA == 2'b01 ? OldPC : ALUSrcA == 2'b10 ? A : 32'h0;
  always_comb
    SrcB = ALUSrcB == 2'b00 ? WriteData : ALUSrcB == 2'b01 ? ImmExt : ALUSrcB == 2'b10 ? 32'd4 : 32'h0;
  // SLT shares the subtractor: sign of A-B corrected by overflow gives signed less-than
  assign sub   = ALUControl == 3'b001 || ALUControl == 3'b101;
  assign arith = ALUControl[2:1] == 2'b00;
  assign b_op  = sub ? ~SrcB : SrcB;
  assign sum   = {1'b0, SrcA} + {1'b0, b_op} + {32'b0, sub};
  assign ovf   = (SrcA[31] == b_op[31]) && (sum[31] != SrcA[31]);
  always_comb begin
    ALUResult = 32'h0;
    case (ALUControl)
      3'b000, 3'b001: ALUResult = sum[31:0];
      3'b010:         ALUResult = SrcA & SrcB;
      3'b011:         ALUResult = SrcA | SrcB;
      3'b100:         ALUResult = SrcA ^ SrcB;
      3'b101:         ALUResult = {31'b0, sum[31] ^ ovf};
`ifdef ALU_SHIFT_EN
      3'b110:         ALUResult = SrcA << SrcB[4:0];
      3'b111:         ALUResult = SrcA >> SrcB[4:0];
`endif
      default:        ALUResult = 32'h0;
    endcase
  end
  assign Zero      = ALUResult == 32'h0;
  assign Negative  = ALUResult[31];
  assign Carry     = arith & sum[32];
  assign Overflow  = arith & ovf;
  assign alu_out_d = ALUResult;
  always_ff @(posedge clk or negedge reset)
    if (!reset) alu_out_q <= 32'h0;
    else        alu_out_q <= alu_out_d;
  assign ALUOut = alu_out_q;
endmodule

// File: tb/tb_riscv_execute_datapath.sv
// tb_riscv_execute_datapath: randomized and directed scoreboard bench for the execute datapath.
// The reference model follows the ALU_SHIFT_EN build option of the design.
module tb_riscv_execute_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC, OldPC, A, WriteData, Result;
  logic [24:0] Inst;
  logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl;
  logic        AddrSrc;
  logic [31:0] Addr, ImmExt, SrcA, SrcB, ALUResult, ALUOut;
  logic        Zero, Negative, Carry, Overflow;

  typedef struct {
    string       nm;
    logic [31:0] addr, imm, sa, sb, res, aluout;
    logic        z, n, c, v;
  } exp_t;

  exp_t        q[$];
  event        sample_ev;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_res;

  riscv_execute_datapath dut (
    .clk(clk), .reset(reset), .PC(PC), .OldPC(OldPC), .A(A), .WriteData(WriteData),
    .Result(Result), .Inst(Inst), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .AddrSrc(AddrSrc), .Addr(Addr), .ImmExt(ImmExt), .SrcA(SrcA),
    .SrcB(SrcB), .ALUResult(ALUResult), .ALUOut(ALUOut), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  function automatic exp_t model(input string nm);
    exp_t        e;
    logic [31:0] ins, a, b, r;
    logic        s;
    longint      sa64, sb64;
    ins = {Inst, 7'b0};
    s = ins[31];
    e.nm   = nm;
    e.addr = AddrSrc ? Result : PC;
    case (ImmSrc)
      2'd0:    e.imm = {{20{s}}, ins[31:20]};
      2'd1:    e.imm = {{20{s}}, ins[31:25], ins[11:7]};
      2'd2:    e.imm = {{20{s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      default: e.imm = {{12{s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
    case (ALUSrcA)
      2'd0: a = PC; 2'd1: a = OldPC; 2'd2: a = A; default: a = 32'h0;
    endcase
    case (ALUSrcB)
      2'd0: b = WriteData; 2'd1: b = e.imm; 2'd2: b = 32'd4; default: b = 32'h0;
    endcase
    e.sa = a; e.sb = b;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    e.c = 1'b0; e.v = 1'b0;
    case (ALUControl)
      3'd0: begin
        r = a + b;
        e.c = (longint'(a) + longint'(b)) > 64'hFFFF_FFFF;
        e.v = (sa64 + sb64) != longint'($signed(r));
      end
      3'd1: begin
        r = a - b;
        e.c = a >= b;
        e.v = (sa64 - sb64) != longint'($signed(r));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa64 < sb64) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
`else
      default: r = 32'h0;
`endif
    endcase
    e.res = r;
    e.z = r == 32'h0;
    e.n = r[31];
    e.aluout = prev_res;
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "Addr", Addr, e.addr);
        chk(e.nm, "ImmExt", ImmExt, e.imm);
        chk(e.nm, "SrcA", SrcA, e.sa);
        chk(e.nm, "SrcB", SrcB, e.sb);
        chk(e.nm, "ALUResult", ALUResult, e.res);
        chk(e.nm, "ALUOut", ALUOut, e.aluout);
        chk(e.nm, "Zero", {31'b0, Zero}, {31'b0, e.z});
        chk(e.nm, "Negative", {31'b0, Negative}, {31'b0, e.n});
        chk(e.nm, "Carry", {31'b0, Carry}, {31'b0, e.c});
        chk(e.nm, "Overflow", {31'b0, Overflow}, {31'b0, e.v});
      end
    end
  end

  task automatic set_vec(input logic [31:0] pc, oldpc, a, wd, res, ins,
                         input logic [1:0] imm, sa, sb, input logic [2:0] ctl, input logic as);
    PC = pc; OldPC = oldpc; A = a; WriteData = wd; Result = res; Inst = ins[31:7];
    ImmSrc = imm; ALUSrcA = sa; ALUSrcB = sb; ALUControl = ctl; AddrSrc = as;
  endtask

  task automatic push(input string nm);
    exp_t e;
    e = model(nm);
    q.push_back(e);
    ->sample_ev;
  endtask

  // Drive after a rising edge, check 2 time units later, and remember the result the next edge latches.
  task automatic step(input string nm, input logic [31:0] pc, oldpc, a, wd, res, ins,
                      input logic [1:0] imm, sa, sb, input logic [2:0] ctl, input logic as);
    exp_t e;
    @(posedge clk);
    #1 set_vec(pc, oldpc, a, wd, res, ins, imm, sa, sb, ctl, as);
    #1 push(nm);
    e = model(nm);
    prev_res = e.res;
  endtask

  initial begin
    exp_t e;
    set_vec(32'h100, 32'h0FC, 32'h3, 32'h9, 32'h0, 32'h0, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0);
    prev_res = 32'h0;
    #2 push("reset_hold");
    e = model("init");
    prev_res = e.res;
    #1 reset = 1'b1;
    step("add_ovf", 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0);
    step("sub_eq", 0, 0, 32'd5, 32'd5, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0);
    step("sub_neg", 0, 0, 32'd3, 32'd5, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0);
    step("slt", 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 2'd0, 2'd2, 2'd0, 3'd5, 1'b0);
    step("imm_i", 0, 0, 0, 0, 0, 32'hFFF00093, 2'd0, 2'd3, 2'd1, 3'd0, 1'b0);
    step("imm_b_oldpc", 0, 32'h2580, 0, 0, 0, 32'hFE000EE3, 2'd2, 2'd1, 2'd1, 3'd0, 1'b0);
    step("pc_plus4", 32'h2580, 0, 0, 0, 32'h1234, 0, 2'd0, 2'd0, 2'd2, 3'd0, 1'b0);
    step("addr_result", 32'h2580, 0, 0, 0, 32'h1234, 0, 2'd0, 2'd0, 2'd2, 3'd0, 1'b1);
    step("sll31", 0, 0, 32'h1, 32'd31, 0, 0, 2'd0, 2'd2, 2'd0, 3'd6, 1'b0);
    step("srl4", 0, 0, 32'h80000000, 32'd4, 0, 0, 2'd0, 2'd2, 2'd0, 3'd7, 1'b0);
    step("pre_reset", 32'h2580, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 1'b0);
    step("hold_2584", 32'h2580, 0, 32'h55, 32'h22, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0);
    #1 reset = 1'b0;
    prev_res = 32'h0;
    #1 push("mid_reset");
    #1 reset = 1'b1;
    e = model("release");
    prev_res = e.res;
    repeat (300) begin
      logic [31:0] ins;
      ins = $urandom;
      step("rand", $urandom, $urandom, $urandom, $urandom, $urandom, ins,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
